// File: rtl/mul_div_unit.sv
// Multiply/divide unit: fixed-latency multiplier plus an optional restoring radix-2 divider.
// Define MDU_DIV_EN to build the divider; without it, ops 4..7 complete with illegal=1.

module mul_div_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            ready,
  output logic            completed,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
  typedef enum logic [0:0] {IDLE, MUL} state_t;
`endif

  state_t            r_state;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [CNT_W-1:0]  r_count;

  logic              w_signA;
  logic              w_signB;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mulRes;

  assign ready = (r_state == IDLE);

  // Sign-extending both operands to 2*XLEN makes one modular product serve all signedness mixes.
  always_comb begin
    w_signA  = (r_op != 2'd3) && r_a[XLEN-1];
    w_signB  = (r_op == 2'd1) && r_b[XLEN-1];
    w_prod   = {{XLEN{w_signA}}, r_a} * {{XLEN{w_signB}}, r_b};
    w_mulRes = (r_op == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] r_rem;
  logic            r_negQ;
  logic            r_negR;
  logic            r_special;

  logic            w_neg1;
  logic            w_neg2;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [XLEN-1:0] w_specRes;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_newRem;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_remFix;

  // r_a doubles as dividend shifter and quotient accumulator; special cases preload their answer there.
  always_comb begin
    w_neg1    = !op[0] && rs1[XLEN-1];
    w_neg2    = !op[0] && rs2[XLEN-1];
    w_mag1    = w_neg1 ? -rs1 : rs1;
    w_mag2    = w_neg2 ? -rs2 : rs2;
    w_div0    = (rs2 == '0);
    w_ovf     = !op[0] && (rs1 == MOST_NEG) && (rs2 == '1);
    if (w_div0)
      w_specRes = op[1] ? rs1 : '1;
    else
      w_specRes = op[1] ? '0 : rs1;
    w_shift   = {r_rem, r_a[XLEN-1]};
    w_ge      = (w_shift >= {1'b0, r_b});
    w_newRem  = w_ge ? XLEN'(w_shift - {1'b0, r_b}) : w_shift[XLEN-1:0];
    w_quo     = r_negQ ? -r_a : r_a;
    w_remFix  = r_negR ? -r_rem : r_rem;
  end
`else
  logic r_illPend;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_count   <= '0;
      completed <= 1'b0;
      illegal   <= 1'b0;
      result    <= '0;
`ifdef MDU_DIV_EN
      r_rem     <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_special <= 1'b0;
`else
      r_illPend <= 1'b0;
`endif
    end else begin
      completed <= 1'b0;
      illegal   <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_count <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_op <= op[1:0];
              if (!op[2]) begin
                r_state   <= MUL;
                r_a       <= rs1;
                r_b       <= rs2;
                r_count   <= MUL_CNT;
`ifndef MDU_DIV_EN
                r_illPend <= 1'b0;
`endif
              end else begin
`ifdef MDU_DIV_EN
                r_state   <= DIV;
                r_a       <= (w_div0 || w_ovf) ? w_specRes : w_mag1;
                r_b       <= w_mag2;
                r_rem     <= '0;
                r_count   <= CNT_W'(XLEN);
                r_negQ    <= w_neg1 ^ w_neg2;
                r_negR    <= w_neg1;
                r_special <= w_div0 || w_ovf;
`else
                r_state   <= MUL;
                r_count   <= '0;
                r_illPend <= 1'b1;
`endif
              end
            end
          end
          MUL: begin
            if (r_count == '0) begin
              r_state   <= IDLE;
              completed <= 1'b1;
`ifdef MDU_DIV_EN
              result    <= w_mulRes;
`else
              result    <= r_illPend ? '0 : w_mulRes;
              illegal   <= r_illPend;
`endif
            end else begin
              r_count <= r_count - CNT_W'(1);
            end
          end
`ifdef MDU_DIV_EN
          DIV: begin
            if (r_special) begin
              r_state   <= IDLE;
              completed <= 1'b1;
              result    <= r_a;
            end else if (r_count != '0) begin
              r_rem   <= w_newRem;
              r_a     <= {r_a[XLEN-2:0], w_ge};
              r_count <= r_count - CNT_W'(1);
            end else begin
              r_state   <= IDLE;
              completed <= 1'b1;
              result    <= r_op[1] ? w_remFix : w_quo;
            end
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (valid 8..64, even).
REQ-002 SHALL have parameter MUL_LATENCY, default 2, cycles from accepted multiply to completed (valid 1..4).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request valid.
REQ-006 SHALL have port op  input  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-007 SHALL have port rs1  input  XLEN  first operand (dividend / multiplicand).
REQ-008 SHALL have port rs2  input  XLEN  second operand (divisor / multiplier).
REQ-009 SHALL have port flush  input  1  abort in-flight operation.
REQ-010 SHALL have port ready  output  1  unit can accept start this cycle.
REQ-011 SHALL have port completed  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result  output  XLEN  operation result.
REQ-013 SHALL have port illegal  output  1  one-cycle pulse with completed when op unsupported.

Function
REQ-014 SHALL use states IDLE, MUL, DIV; ready SHALL equal (state == IDLE).
REQ-015 SHALL accept a request when start && ready && !flush, latching op, rs1, rs2 at that edge (cycle T).
REQ-016 SHALL ignore start while ready is 0; no queuing.
REQ-017 SHALL compute mul as low XLEN bits of the 2*XLEN product; mulh signed x signed, mulhsu signed rs1 x unsigned rs2, mulhu unsigned x unsigned, all returning high XLEN bits.
REQ-018 SHALL assert completed at cycle T+MUL_LATENCY for multiplies; IDLE->MUL at T, MUL->IDLE on the edge setting completed.
REQ-019 SHALL compute div/divu/rem/remu with a restoring radix-2 iterator, one quotient bit per cycle, XLEN iterations plus one sign-fixup cycle; completed at T+XLEN+1.
REQ-020 SHALL, for signed ops, divide magnitudes; quotient negated when operand signs differ, remainder takes sign of rs1.
REQ-021 SHALL, on divisor zero, complete at T+1 with quotient all-ones and remainder rs1 (signed and unsigned).
REQ-022 SHALL, on signed overflow (rs1 = most-negative, rs2 = -1), complete at T+1 with quotient rs1 and remainder 0.
REQ-023 SHALL return to IDLE on the edge setting completed, so ready=1 in the completed cycle and back-to-back start is accepted then.
REQ-024 SHALL hold result stable from completed until the next completed; completed and illegal SHALL be 0 in all other cycles.
REQ-025 SHALL, on flush=1 in any state, enter IDLE at the next edge with no completed pulse; result unchanged.
REQ-026 SHALL give flush priority over a simultaneous start (request dropped).
REQ-027 SHALL, when flush coincides with the cycle an operation would complete, suppress completed and leave result unchanged.

Reset
REQ-028 SHALL, while rstn=0, immediately force state IDLE, ready=1, completed=0, illegal=0, result=0, iteration counter=0.
REQ-029 SHALL abandon any in-flight operation on reset mid-operation; first completed after release only follows a new accepted start.

Configuration
REQ-030 SHALL compile the divider only when macro MDU_DIV_EN is defined.
REQ-031 SHALL, with MDU_DIV_EN defined, implement REQ-019..REQ-022 and never assert illegal.
REQ-032 SHALL, without MDU_DIV_EN, complete ops 4..7 at T+1 with result 0 and illegal=1; state DIV and iterator absent; multiplies unchanged.

Verification
REQ-033 SHALL cover: XLEN=32, MUL_LATENCY=2, mulh rs1=0x80000000 rs2=0x80000000 at T -> completed at T+2, result 0x40000000.
REQ-034 SHALL cover: div rs1=-7 (0xFFFFFFF9) rs2=2 -> completed at T+33, result 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF.
REQ-035 SHALL cover: divu rs1=5 rs2=0 -> completed at T+1, result 0xFFFFFFFF; remu -> 5; div 0x80000000 / 0xFFFFFFFF -> T+1, result 0x80000000.
REQ-036 SHALL cover: divu 100/7 started, flush at T+10 -> no completed, ready=1 at T+11, result unchanged; start+flush same cycle -> ignored.
REQ-037 SHALL cover: mul 3x4 completing, new mulhu 0xFFFFFFFF x 0xFFFFFFFF started in completed cycle -> results 12 then 0xFFFFFFFE, two completed pulses.
REQ-038 SHALL cover: rstn low mid-divide -> outputs at reset values immediately; build without MDU_DIV_EN, div 10/2 -> T+1, result 0, illegal=1.
